// File: rtl/latch_rf_write_ctrl.sv
// Two-port round-robin write sequencer for a latch-based register file.
// Every write runs SETUP -> PULSE -> HOLD, and every latch-facing output comes straight from a flop.
module latch_rf_write_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ack,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ack,
  output logic                err,
  output logic                busy,
  output logic [DATA_W-1:0]   lat_d,
  output logic [NUM_REGS-1:0] lat_en
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t              state, state_nx;
  logic                rr_b;      // last granted port was B
  logic                gnt_b_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                grant, gnt_b, in_range;
  logic [NUM_REGS-1:0] en_nx;

  always_comb begin
    grant    = a_req | b_req;
    gnt_b    = b_req & (~a_req | ~rr_b);
    in_range = 32'(addr_q) < NUM_REGS;
    state_nx = state;
    en_nx    = '0;
    case (state)
      IDLE:  if (grant) state_nx = SETUP;
      SETUP: begin
        state_nx = PULSE;
        // The decode is done one cycle early so that lat_en itself is a plain register.
        if (in_range) en_nx = NUM_REGS'(1) << addr_q;
      end
      PULSE: state_nx = HOLD;
      HOLD:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_b    <= 1'b1;
      gnt_b_q <= 1'b0;
      addr_q  <= '0;
      lat_d   <= '0;
      lat_en  <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state  <= state_nx;
      lat_en <= en_nx;
      a_ack  <= (state == PULSE) & ~gnt_b_q;
      b_ack  <= (state == PULSE) & gnt_b_q;
      err    <= (state == PULSE) & ~in_range;
      // lat_d doubles as the captured data register; it is stable from SETUP until the next grant.
      if (state == IDLE && grant) begin
        gnt_b_q <= gnt_b;
        rr_b    <= gnt_b;
        addr_q  <= gnt_b ? b_addr : a_addr;
        lat_d   <= gnt_b ? b_data : a_data;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_rf_write_ctrl.sv
// Bench for latch_rf_write_ctrl: an 8-word and a 6-word instance share the same stimulus.
// A transaction-level model is checked every cycle, alongside directed literal checks.
module tb_latch_rf_write_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 0, rst = 0;
  logic a_req = 0, b_req = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  logic a_ack8, b_ack8, err8, busy8; logic [DW-1:0] lat_d8; logic [7:0] lat_en8;
  logic a_ack6, b_ack6, err6, busy6; logic [DW-1:0] lat_d6; logic [5:0] lat_en6;

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 0;

  latch_rf_write_ctrl #(.NUM_REGS(8), .DATA_W(DW), .ADDR_W(AW)) u8 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack8),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack8),
    .err(err8), .busy(busy8), .lat_d(lat_d8), .lat_en(lat_en8));

  latch_rf_write_ctrl #(.NUM_REGS(6), .DATA_W(DW), .ADDR_W(AW)) u6 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack6),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack6),
    .err(err6), .busy(busy6), .lat_d(lat_d6), .lat_en(lat_en6));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requesters: hold {addr,data} of the queue head until its ack, then present the next entry.
  logic [AW+DW-1:0] qa[$], qb[$];
  always @(negedge clk) begin
    if (a_ack8 && qa.size() > 0) void'(qa.pop_front());
    if (b_ack8 && qb.size() > 0) void'(qb.pop_front());
    a_req = qa.size() > 0;
    b_req = qb.size() > 0;
    if (a_req) {a_addr, a_data} = qa[0];
    if (b_req) {b_addr, b_data} = qb[0];
  end

  // Event logs from the 8-word instance, plus ack/err cycles of the 6-word instance.
  int en_cyc[$], ack_cyc[$], b6_ack[$], e6[$], en6_cnt;
  logic [7:0] en_val[$];
  bit ack_port[$];
  always @(negedge clk) begin
    if (lat_en8 != 0) begin en_cyc.push_back(cyc); en_val.push_back(lat_en8); end
    if (a_ack8) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b0); end
    if (b_ack8) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b1); end
    if (b_ack6) b6_ack.push_back(cyc);
    if (err6)   e6.push_back(cyc);
    if (lat_en6 != 0) en6_cnt++;
  end

  task automatic clr_logs();
    en_cyc.delete(); en_val.delete(); ack_cyc.delete(); ack_port.delete();
    b6_ack.delete(); e6.delete(); en6_cnt = 0;
  endtask

  // Model: a granted write is a record plus its age in cycles since the grant (1..3), 0 when idle.
  int age = 0;
  bit m_port = 0, rr_b = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_d = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0; m_d = '0; rr_b = 1;
    end else if (age == 0) begin
      if (a_req || b_req) begin
        m_port = (a_req && b_req) ? !rr_b : b_req;
        m_addr = m_port ? b_addr : a_addr;
        m_d    = m_port ? b_data : a_data;
        rr_b   = m_port;
        age    = 1;
      end
    end else begin
      age = (age == 3) ? 0 : age + 1;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("busy8",  busy8,  age != 0);
    chk("busy6",  busy6,  age != 0);
    chk("lat_d8", lat_d8, m_d);
    chk("lat_d6", lat_d6, m_d);
    chk("lat_en8", lat_en8, (age == 2 && m_addr < 8) ? (64'd1 << m_addr) : 64'd0);
    chk("lat_en6", lat_en6, (age == 2 && m_addr < 6) ? (64'd1 << m_addr) : 64'd0);
    chk("a_ack8", a_ack8, age == 3 && !m_port);
    chk("b_ack8", b_ack8, age == 3 && m_port);
    chk("a_ack6", a_ack6, age == 3 && !m_port);
    chk("b_ack6", b_ack6, age == 3 && m_port);
    chk("err8", err8, age == 3 && m_addr >= 8);
    chk("err6", err6, age == 3 && m_addr >= 6);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1; qa.delete(); qb.delete();
    tick(2);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    tick(3);
    rst = 0;
    chk_on = 1;

    // Idle after reset
    clr_logs();
    tick(20);
    chk("idle_acks", ack_cyc.size(), 0);
    chk("idle_en", lat_en8, 0);
    chk("idle_d", lat_d8, 0);
    chk("idle_busy", busy8, 0);

    // Single write, A addr 3
    qa.push_back({5'd3, 32'hDEADBEEF});
    @(negedge clk);
    @(negedge clk);
    chk("sw_setup_d", lat_d8, 32'hDEADBEEF);
    chk("sw_setup_en", lat_en8, 0);
    chk("sw_setup_busy", busy8, 1);
    @(negedge clk);
    chk("sw_pulse_en", lat_en8, 8'h08);
    chk("sw_pulse_ack", a_ack8, 0);
    @(negedge clk);
    chk("sw_hold_ack", a_ack8, 1);
    chk("sw_hold_en", lat_en8, 0);
    chk("sw_hold_busy", busy8, 1);
    @(negedge clk);
    chk("sw_idle_ack", a_ack8, 0);
    chk("sw_idle_busy", busy8, 0);
    chk("sw_idle_d", lat_d8, 32'hDEADBEEF);
    tick(2);

    // Simultaneous requests from reset: A then B, pulses 4 cycles apart
    do_reset();
    clr_logs();
    qa.push_back({5'd1, 32'h11});
    qb.push_back({5'd2, 32'h22});
    tick(12);
    chk("sim_npulse", en_val.size(), 2);
    if (en_val.size() == 2) begin
      chk("sim_en0", en_val[0], 8'h02);
      chk("sim_en1", en_val[1], 8'h04);
      chk("sim_gap", en_cyc[1] - en_cyc[0], 4);
    end
    chk("sim_nack", ack_port.size(), 2);
    if (ack_port.size() == 2) begin
      chk("sim_ack0_port", ack_port[0], 0);
      chk("sim_ack1_port", ack_port[1], 1);
    end

    // Continuous requests on both ports: strict alternation
    do_reset();
    clr_logs();
    for (int i = 0; i < 4; i++) begin
      qa.push_back({5'(i), 32'hA000_0000 + 32'(i)});
      qb.push_back({5'(i + 4), 32'hB000_0000 + 32'(i)});
    end
    tick(40);
    chk("rr_nack", ack_port.size(), 8);
    if (ack_port.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("rr_order", ack_port[i], i % 2);
        if (i > 0) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
      end

    // Out of range on the 6-word instance, valid word 7 on the 8-word instance
    clr_logs();
    qb.push_back({5'd7, 32'h0000_00B7});
    tick(8);
    chk("oor_en6_pulses", en6_cnt, 0);
    chk("oor_b6_acks", b6_ack.size(), 1);
    chk("oor_err6", e6.size(), 1);
    if (b6_ack.size() == 1 && e6.size() == 1) chk("oor_same_cycle", e6[0], b6_ack[0]);
    chk("oor_en8", en_val.size(), 1);
    if (en_val.size() == 1) chk("oor_en8_val", en_val[0], 8'h80);
    qa.push_back({5'd31, 32'h3131_3131});
    tick(8);

    // Async reset in the middle of PULSE
    clr_logs();
    qa.push_back({5'd2, 32'h0000_CAFE});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mr_pulse_en", lat_en8, 8'h04);
    #1 rst = 1; qa.delete();
    #1;
    chk("mr_async_en", lat_en8, 0);
    chk("mr_async_busy", busy8, 0);
    chk("mr_async_d", lat_d8, 0);
    tick(2);
    rst = 0;
    tick(4);
    chk("mr_no_ack", ack_cyc.size(), 0);
    qa.push_back({5'd5, 32'h55});
    tick(6);
    chk("mr_after_ack", ack_cyc.size(), 1);
    chk("mr_after_en", en_val.size(), 2);
    if (en_val.size() == 2) chk("mr_after_en_val", en_val[1], 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/latch_rf_write_ctrl.md
Name: latch_rf_write_ctrl

Overview:
Write sequencer and arbiter for a latch-based register file built from level-sensitive, active-high-enable D latches. It accepts write requests from two requesters (port A and port B) and arbitrates between them round-robin. For each granted write it drives a shared data bus to all latches, then sequences a glitch-free, one-hot enable pulse with a setup phase before and a hold phase after. It sits between the CPU writeback and debug/load paths and the register-file latch array.

Parameters:
NUM_REGS, 8, number of latch words (valid range 2..32)
DATA_W, 32, width of each latch word
ADDR_W, 5, width of the request address ports; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
a_req  input  1  port A write request; level, held until a_ack
a_addr  input  ADDR_W  port A target register index
a_data  input  DATA_W  port A write data
a_ack  output  1  one-cycle pulse: port A write complete
b_req  input  1  port B write request; level, held until b_ack
b_addr  input  ADDR_W  port B target register index
b_data  input  DATA_W  port B write data
b_ack  output  1  one-cycle pulse: port B write complete
err  output  1  one-cycle pulse coincident with ack: address was out of range, no latch written
busy  output  1  high in every state except IDLE
lat_d  output  DATA_W  shared D bus to all latch words
lat_en  output  NUM_REGS  one-hot latch enables; bit i drives EN of word i

Behaviour:
- Reset (async, rst=1): state=IDLE; lat_en=0 immediately, with no clock needed; lat_d=0; a_ack=b_ack=err=0; busy=0; rr_last=B, so A wins the first tie.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE. Each state lasts exactly 1 cycle except IDLE.
- IDLE:
  - Sample a_req and b_req.
  - If exactly one is high, grant it. If both are high, grant the port not equal to rr_last.
  - On grant: capture the granted addr and data into internal registers, update rr_last to the granted port, go to SETUP.
  - With no request, stay in IDLE.
- SETUP: lat_d = captured data; lat_en=0.
- PULSE: lat_d unchanged; lat_en = one-hot(captured addr) if addr < NUM_REGS, else all zero.
- HOLD:
  - lat_en=0; lat_d unchanged.
  - Ack of the granted port = 1.
  - err=1 if addr >= NUM_REGS.
- Back in IDLE, lat_d keeps its last value and changes only at the next SETUP.
- lat_en must come directly from registers, with no combinational decode after the flop, so the latches never see glitches. At most one bit is ever high.
- Latency: request high in IDLE cycle t gives SETUP t+1, PULSE t+2, ack in t+3 (HOLD), IDLE t+4.
- Minimum spacing between grants is 4 cycles.
- Handshake:
  - Requesters keep req/addr/data stable until they see ack, then deassert req on the same edge that samples ack=1.
  - A req still high in the IDLE cycle after HOLD is treated as a new request, so back-to-back writes are legal.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B...
- Requests that arrive or change while busy are ignored until IDLE. addr/data changes after grant have no effect.
- Reset mid-operation: all outputs return to their reset values asynchronously and no ack is issued. Word content after reset during PULSE is undefined; the word is not written if reset occurs during SETUP.

Test Plan:
- Reset then idle: rst pulse with no reqs -> lat_en=0, lat_d=0, busy=0, no ack for 20 cycles.
- Single write: a_req, a_addr=3, a_data=0xDEADBEEF at cycle t ->
  - lat_d=0xDEADBEEF from t+1;
  - lat_en=8'b0000_1000 only in t+2;
  - a_ack=1 only in t+3;
  - busy high t+1..t+3.
- Simultaneous requests: both req from reset with A addr=1 data=0x11 and B addr=2 data=0x22, held until each ack ->
  - A's enable pulse and ack first, then B's;
  - B's PULSE exactly 4 cycles after A's.
- Starvation check: both reqs reasserted immediately after every ack for 8 grants -> grant order A, B, A, B, A, B, A, B.
- Out-of-range address: with NUM_REGS=6, b_addr=7 -> lat_en stays 0; b_ack and err both 1 in the same cycle.
- Async reset mid-pulse: assert rst during PULSE without a clock edge -> lat_en=0 immediately. After release: IDLE, no ack, and a subsequent write completes normally.
